// File: rtl/cache_alloc_pkg.sv
// ---------------------------------------------------------------------------
// cache_alloc_pkg : shared constants and helpers for cache slot allocators
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cache_alloc_pkg;

  localparam int MAX_LOG_ENTRIES = 6;

  // Smallest r with 2**r >= slots.
  function automatic int clog2_slots(input int slots);
    int r;
    r = 0;
    while ((1 << r) < slots) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder : enable-gated index to one-hot mask decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module onehot_decoder
  import cache_alloc_pkg::*;
#(
  parameter int LOG_INPUTS = 2
) (
  input  logic                     en,
  input  logic [LOG_INPUTS-1:0]    idx,
  output logic [2**LOG_INPUTS-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out[idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/slot_allocator.sv
// ---------------------------------------------------------------------------
// slot_allocator : busy-bitmap slot tracker, lowest-free grant, indexed release
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module slot_allocator
  import cache_alloc_pkg::*;
#(
  parameter int LOG_ENTRIES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_req,
  output logic                      alloc_gnt,
  output logic [LOG_ENTRIES-1:0]    alloc_idx,
  input  logic                      free_valid,
  input  logic [LOG_ENTRIES-1:0]    free_idx,
  output logic [2**LOG_ENTRIES-1:0] busy_mask,
  output logic [LOG_ENTRIES:0]      count,
  output logic                      full,
  output logic                      empty,
  output logic                      free_err
);

  localparam int N  = 1 << LOG_ENTRIES;
  localparam int CW = LOG_ENTRIES + 1;

  if (LOG_ENTRIES < 1 || LOG_ENTRIES > MAX_LOG_ENTRIES) begin : g_param_check
    $error("slot_allocator: LOG_ENTRIES out of range");
  end

  logic [N-1:0]           busy_q, busy_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   free_err_q, free_err_d;
  logic [LOG_ENTRIES-1:0] free_slot;
  logic [N-1:0]           set_mask, clear_mask;
  logic                   legal_free;

  assign full  = (count_q == CW'(N));
  assign empty = (count_q == '0);

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    free_slot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_slot = LOG_ENTRIES'(i);
    end
  end

  assign alloc_gnt  = alloc_req & ~full;
  assign alloc_idx  = alloc_gnt ? free_slot : '0;
  assign legal_free = free_valid & busy_q[free_idx];

  onehot_decoder #(.LOG_INPUTS(LOG_ENTRIES)) u_set_dec (
    .en  (alloc_gnt),
    .idx (free_slot),
    .out (set_mask)
  );

  onehot_decoder #(.LOG_INPUTS(LOG_ENTRIES)) u_clear_dec (
    .en  (free_valid),
    .idx (free_idx),
    .out (clear_mask)
  );

  // Set is applied after clear: an illegal free aimed at the slot being
  // granted this cycle must not undo the grant.
  always_comb begin
    busy_d     = (busy_q & ~clear_mask) | set_mask;
    count_d    = count_q + CW'(alloc_gnt) - CW'(legal_free);
    free_err_d = free_valid & ~busy_q[free_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      count_q    <= '0;
      free_err_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      count_q    <= count_d;
      free_err_q <= free_err_d;
    end
  end

  assign busy_mask = busy_q;
  assign count     = count_q;
  assign free_err  = free_err_q;

endmodule

`default_nettype wire

// File: tb/tb_slot_allocator.sv
// ---------------------------------------------------------------------------
// tb_slot_allocator : directed vector table, reset corner case, random vs model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_slot_allocator;

  localparam int LOG = 2;
  localparam int N   = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           alloc_req;
  logic           alloc_gnt;
  logic [LOG-1:0] alloc_idx;
  logic           free_valid;
  logic [LOG-1:0] free_idx;
  logic [N-1:0]   busy_mask;
  logic [LOG:0]   count;
  logic           full;
  logic           empty;
  logic           free_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  slot_allocator #(.LOG_ENTRIES(LOG)) dut (
    .clk        (clk),
    .reset      (reset),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_idx  (alloc_idx),
    .free_valid (free_valid),
    .free_idx   (free_idx),
    .busy_mask  (busy_mask),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .free_err   (free_err)
  );

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  // Directed vectors: inputs plus the state/outputs expected before the edge.
  typedef struct {
    logic           req;
    logic           fv;
    logic [LOG-1:0] fidx;
    logic           gnt;
    logic [LOG-1:0] idx;
    logic [N-1:0]   busy;
    int             cnt;
    logic           err;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic req, logic fv, logic [LOG-1:0] fidx, logic gnt,
                              logic [LOG-1:0] idx, logic [N-1:0] busy, int cnt, logic err);
    vec_t v;
    v.req = req; v.fv = fv; v.fidx = fidx; v.gnt = gnt; v.idx = idx;
    v.busy = busy; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  // Behavioural model: an array of per-slot flags and a plain integer count.
  bit mbusy[N];
  int mcount;
  bit merr;

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = mbusy[i];
    return m;
  endfunction

  task automatic check_state(input string tag, input int step, input logic [N-1:0] busy,
                             input int cnt, input logic err);
    chk({tag, ".busy_mask"}, step, 32'(busy_mask), 32'(busy));
    chk({tag, ".count"},     step, 32'(count),     32'(cnt));
    chk({tag, ".full"},      step, 32'(full),      32'(cnt == N));
    chk({tag, ".empty"},     step, 32'(empty),     32'(cnt == 0));
    chk({tag, ".free_err"},  step, 32'(free_err),  32'(err));
  endtask

  initial begin
    int    gnt_e;
    int    idx_e;
    bit    legal;
    reset      = 1'b1;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_idx   = '0;

    tbl[0]  = mk(1, 0, 0, 1, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 1, 4'b0001, 1, 0);
    tbl[2]  = mk(1, 0, 0, 1, 2, 4'b0011, 2, 0);
    tbl[3]  = mk(1, 0, 0, 1, 3, 4'b0111, 3, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 4'b1111, 4, 0);
    tbl[5]  = mk(0, 1, 2, 0, 0, 4'b1111, 4, 0);
    tbl[6]  = mk(1, 0, 0, 1, 2, 4'b1011, 3, 0);
    tbl[7]  = mk(0, 1, 2, 0, 0, 4'b1111, 4, 0);
    tbl[8]  = mk(1, 1, 0, 1, 2, 4'b1011, 3, 0);
    tbl[9]  = mk(1, 0, 0, 1, 0, 4'b1110, 3, 0);
    tbl[10] = mk(1, 1, 1, 0, 0, 4'b1111, 4, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 4'b1101, 3, 0);
    tbl[12] = mk(0, 1, 2, 0, 0, 4'b1100, 2, 0);
    tbl[13] = mk(0, 1, 3, 0, 0, 4'b1000, 1, 0);
    tbl[14] = mk(1, 0, 0, 1, 0, 4'b0000, 0, 0);
    tbl[15] = mk(0, 1, 3, 0, 0, 4'b0001, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 4'b0001, 1, 1);
    tbl[17] = mk(1, 1, 1, 1, 1, 4'b0001, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 4'b0011, 2, 1);
    tbl[19] = mk(1, 0, 0, 1, 2, 4'b0011, 2, 0);

    // Reset state while reset is held.
    #12;
    check_state("reset", 0, 4'b0000, 0, 1'b0);
    chk("reset.alloc_gnt", 0, 32'(alloc_gnt), 32'd0);
    chk("reset.alloc_idx", 0, 32'(alloc_idx), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int s = 0; s < 20; s++) begin
      alloc_req  = tbl[s].req;
      free_valid = tbl[s].fv;
      free_idx   = tbl[s].fidx;
      #1;
      check_state("vec", s, tbl[s].busy, tbl[s].cnt, tbl[s].err);
      chk("vec.alloc_gnt", s, 32'(alloc_gnt), 32'(tbl[s].gnt));
      chk("vec.alloc_idx", s, 32'(alloc_idx), 32'(tbl[s].idx));
      @(posedge clk);
      @(negedge clk);
    end

    // Busy is now 0111; queue an illegal free so a free_err pulse is pending,
    // then assert reset between edges and expect everything cleared at once.
    alloc_req  = 1'b0;
    free_valid = 1'b1;
    free_idx   = 2'd3;
    @(posedge clk);
    @(negedge clk);
    free_valid = 1'b0;
    #1;
    check_state("pre_rst", 0, 4'b0111, 3, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_state("mid_rst", 0, 4'b0000, 0, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    alloc_req = 1'b1;
    #1;
    chk("post_rst.alloc_gnt", 0, 32'(alloc_gnt), 32'd1);
    chk("post_rst.alloc_idx", 0, 32'(alloc_idx), 32'd0);
    @(posedge clk);
    @(negedge clk);
    alloc_req = 1'b0;
    #1;
    check_state("post_rst", 1, 4'b0001, 1, 1'b0);

    // Resynchronise the model with a fresh reset, then random traffic.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    mcount = 0;
    merr   = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 2000; s++) begin
      alloc_req  = ($urandom_range(0, 99) < 55);
      free_valid = ($urandom_range(0, 99) < 45);
      free_idx   = LOG'($urandom_range(0, N - 1));
      #1;
      gnt_e = (alloc_req && mcount < N) ? 1 : 0;
      idx_e = 0;
      if (gnt_e == 1) begin
        for (int i = N - 1; i >= 0; i--) if (!mbusy[i]) idx_e = i;
      end
      check_state("rnd", s, model_mask(), mcount, merr);
      chk("rnd.alloc_gnt", s, 32'(alloc_gnt), 32'(gnt_e));
      chk("rnd.alloc_idx", s, 32'(alloc_idx), 32'(idx_e));
      legal = free_valid && mbusy[free_idx];
      merr  = free_valid && !legal;
      if (legal) mbusy[free_idx] = 1'b0;
      if (gnt_e == 1) mbusy[idx_e] = 1'b1;
      mcount = mcount + gnt_e - (legal ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/slot_allocator.md
Name: slot_allocator

Overview:
- Tracks occupancy of 2**LOG_ENTRIES cache-side slots (MSHRs or fill buffers) in a registered busy bitmap.
- Allocation grants the lowest-numbered free slot. Release takes a slot index and decodes it to a one-hot clear mask, the index-to-bit direction of the lowest-set-bit encoder used elsewhere in the caches.
- Sits between the cache miss path (allocate) and the memory response path (release).

Parameters:
- LOG_ENTRIES, 2, log2 of slot count; N = 2**LOG_ENTRIES; legal range 1..6.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- alloc_req  input  1  requester wants a slot this cycle.
- alloc_gnt  output  1  slot granted this cycle.
- alloc_idx  output  LOG_ENTRIES  index of granted slot; meaningful only when alloc_gnt=1, else 0.
- free_valid  input  1  release a slot this cycle.
- free_idx  input  LOG_ENTRIES  slot to release.
- busy_mask  output  N  registered busy bitmap; bit i=1 means slot i is allocated.
- count  output  LOG_ENTRIES+1  registered number of busy slots, 0..N.
- full  output  1  count==N (combinational from registers).
- empty  output  1  count==0.
- free_err  output  1  registered one-cycle pulse, set when the previous cycle released an idle slot.

Behaviour:
- Reset (asynchronous assert, synchronous release): busy_mask=0, count=0, free_err=0; hence full=0, empty=1, alloc_gnt=0, alloc_idx=0.
- Grant path, zero latency, combinational from registered state:
  - alloc_gnt = alloc_req & ~full.
  - alloc_idx = lowest i with busy_mask[i]==0.
  - No request queuing; the requester holds alloc_req until granted.
- Allocate update: on a clk edge with alloc_gnt=1, busy_mask[alloc_idx]<=1.
- Release update:
  - On a clk edge with free_valid=1 and busy_mask[free_idx]==1: busy_mask[free_idx]<=0.
  - The clear mask comes from onehot decode of free_idx, gated by free_valid.
- Illegal release: free_valid=1 with busy_mask[free_idx]==0 → no state change from the release, free_err<=1 for exactly one cycle. free_err<=0 in every other cycle.
- Same-cycle allocate and release:
  - Both act on pre-edge state, and both take effect at the same edge.
  - A slot being released is not re-grantable until the next cycle.
  - full at the start of the cycle → alloc denied even with a valid free.
  - count is unchanged when both succeed.
- count update: count <= count + gnt - legal_free, computed in LOG_ENTRIES+1 bits; it can never wrap given the rules above.
- Invariant: count == popcount(busy_mask) in every cycle. Implement it as an explicit register; do not recompute it from the mask.
- Wrap-around: none; indices are fixed, and alloc always picks the lowest free slot.
- Reset mid-operation: all slots become free immediately, and a pending free_err pulse is cancelled.

Decomposition:
- Package cache_alloc_pkg holds a function clog2_slots and a constant MAX_LOG_ENTRIES=6; nothing depends on the instance parameter.
- One sub-module: onehot_decoder.
  - Parameter LOG_INPUTS; inputs en, idx[LOG_INPUTS]; output out[2**LOG_INPUTS].
  - out = en ? (1<<idx) : 0.
  - Instantiated for the release clear mask; the same module is used for the allocate set mask.
- The lowest-free search is a combinational loop inside slot_allocator.

Test Plan (LOG_ENTRIES=2):
- Reset, then alloc_req=1 for 4 cycles → alloc_idx 0,1,2,3 with gnt=1 each cycle; busy_mask=1111, count=4, full=1; a 5th cycle gives alloc_gnt=0.
- From busy_mask=1111: free idx 2, then next cycle alloc → alloc_idx=2; busy_mask back to 1111.
- From busy_mask=1011, same cycle alloc_req=1 and free_valid=1 idx 0 → alloc_idx=2, next busy_mask=1110, count stays 3.
- Full (1111) with same-cycle alloc_req and free idx 1 → alloc_gnt=0; next busy_mask=1101, count=3.
- From busy_mask=0001, free idx 3 → busy_mask unchanged, free_err=1 next cycle only, count stays 1.
- With busy_mask=0111, assert reset mid-cycle → busy_mask=0, count=0, empty=1 immediately (asynchronous); the first alloc after release gives alloc_idx=0.
